stream_minmax: RTL and testbench
================================

STREAM_MINMAX -- requirements
Module: stream_minmax

Interface
REQ-001 Parameter WIDTH, default 32, sample width in bits (unsigned).
REQ-002 Parameter CNT_W, default 16, beat-counter width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 in_valid  input  1  sample present on in_data.
REQ-006 in_ready  output  1  block can accept a sample.
REQ-007 in_data  input  WIDTH  unsigned sample.
REQ-008 in_last  input  1  final sample of the current frame.
REQ-009 out_valid  output  1  frame result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 out_max  output  WIDTH  largest sample of the frame.
REQ-012 out_min  output  WIDTH  smallest sample of the frame.
REQ-013 out_count  output  CNT_W  beats in the frame, saturating.
REQ-014 out_all_eq  output  1  every sample in the frame was equal.

Function
REQ-015 States: IDLE, ACCUM and REPORT; a beat transfers when in_valid and in_ready are both high.
REQ-016 in_ready is high in IDLE and ACCUM and low in REPORT.
REQ-017 IDLE beat loads max=min=in_data, count=1 and all_eq=1, then moves to ACCUM, or to REPORT if in_last is high.
REQ-018 ACCUM beat updates max if in_data>max and min if in_data<min, clears all_eq if in_data!=max or in_data!=min, and increments count; it moves to REPORT if in_last is high.
REQ-019 Comparisons are unsigned over the full WIDTH; on equality the stored values are kept.
REQ-020 count saturates at 2^CNT_W-1 and does not wrap.
REQ-021 out_valid rises the cycle after the in_last beat transfers, giving one-cycle latency.
REQ-022 In REPORT, out_valid stays high and outputs stay stable until out_ready is high, with no timeout.
REQ-023 On REPORT with out_ready high, the next state is IDLE; no input beat is accepted in that same cycle.
REQ-024 Result outputs are registered and hold the last reported frame's values outside REPORT.
REQ-025 in_valid low in ACCUM holds all state; frames have no length limit.

Reset
REQ-026 When rst_n is low, the state is IDLE, out_valid=0, out_max=0, out_min=0, out_count=0 and out_all_eq=0.
REQ-027 When rst_n is low, in_ready is 0; it returns to 1 on the first clock edge after release.
REQ-028 Reset in mid-frame or in REPORT discards the partial or pending result, and no out_valid follows.

Configuration
REQ-029 With macro STREAM_MINMAX_INDEX_EN defined, the block adds outputs out_max_idx and out_min_idx, each CNT_W wide.
REQ-030 These indices are the zero-based beat position of the first occurrence of the max and of the min; they reset to 0 and saturate with count.
REQ-031 Without STREAM_MINMAX_INDEX_EN, the ports and their registers are absent and all other behaviour is identical.

Structure
REQ-032 Package stream_minmax_pkg holds the state enum (IDLE, ACCUM, REPORT) and the default WIDTH and CNT_W constants.
REQ-033 One sub-module, mag_cmp, is a combinational WIDTH-bit comparator with gt, eq and lt outputs.
REQ-034 The block instantiates mag_cmp twice: sample against max and sample against min.

Verification
REQ-035 The bench covers a frame of 10,10 (last on the 2nd beat) -> out_max=10, out_min=10, out_count=2, out_all_eq=1.
REQ-036 The bench covers a frame of 100,120,50,556,9807 -> max=9807, min=50, count=5, all_eq=0; with the index macro, max_idx=4 and min_idx=2.
REQ-037 The bench covers a single beat of 0xFFFFFFFF with last -> max=min=0xFFFFFFFF, count=1, with out_valid exactly one cycle after the transfer.
REQ-038 The bench covers out_ready held low for 5 cycles after out_valid -> outputs stable, in_ready=0, and in_valid pulses ignored.
REQ-039 The bench covers CNT_W=2 with a 6-beat frame -> out_count=3 (saturated).
REQ-040 The bench covers rst_n pulsed low after 2 beats of 7,3, then a frame of 5 -> the only result is max=min=5, count=1.

Source files
------------

// File: rtl/stream_minmax_pkg.sv
// stream_minmax_pkg: shared state encoding and default widths for stream_minmax.
package stream_minmax_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;
endpackage

// File: rtl/stream_minmax_mag_cmp.sv
// mag_cmp: combinational unsigned magnitude comparator of i_a against i_b.
module mag_cmp
    import stream_minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_gt,
    output logic             o_eq,
    output logic             o_lt
);
    assign o_gt = i_a > i_b;
    assign o_eq = i_a == i_b;
    assign o_lt = i_a < i_b;
endmodule

// File: rtl/stream_minmax.sv
// stream_minmax: per-frame max/min/count/all-equal reducer; STREAM_MINMAX_INDEX_EN adds first-occurrence beat indices.
module stream_minmax
    import stream_minmax_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [WIDTH-1:0] out_min,
    output logic [CNT_W-1:0] out_count,
    output logic             out_all_eq
`ifdef STREAM_MINMAX_INDEX_EN
    ,
    output logic [CNT_W-1:0] out_max_idx,
    output logic [CNT_W-1:0] out_min_idx
`endif
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_alive;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] r_min;
    logic [CNT_W-1:0] r_cnt;
    logic             r_eq;
    logic [WIDTH-1:0] r_out_max;
    logic [WIDTH-1:0] r_out_min;
    logic [CNT_W-1:0] r_out_cnt;
    logic             r_out_eq;
    logic             w_beat;
    logic             w_first;
    logic             w_gt_max;
    logic             w_eq_max;
    logic             w_lt_max;
    logic             w_gt_min;
    logic             w_eq_min;
    logic             w_lt_min;
    logic             w_unused;
    logic [WIDTH-1:0] w_max_nxt;
    logic [WIDTH-1:0] w_min_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_eq_nxt;

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_max (
        .i_a  (in_data),
        .i_b  (r_max),
        .o_gt (w_gt_max),
        .o_eq (w_eq_max),
        .o_lt (w_lt_max)
    );

    mag_cmp #(.WIDTH(WIDTH)) u_cmp_min (
        .i_a  (in_data),
        .i_b  (r_min),
        .o_gt (w_gt_min),
        .o_eq (w_eq_min),
        .o_lt (w_lt_min)
    );

    assign w_unused  = w_lt_max | w_gt_min;
    // r_alive keeps in_ready low until the first edge after reset release
    assign in_ready  = r_alive & (r_state != REPORT);
    assign out_valid = r_state == REPORT;
    assign w_beat    = in_valid & in_ready;
    assign w_first   = r_state == IDLE;
    assign w_max_nxt = (w_first | w_gt_max) ? in_data : r_max;
    assign w_min_nxt = (w_first | w_lt_min) ? in_data : r_min;
    assign w_cnt_nxt = w_first ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + 1'b1);
    assign w_eq_nxt  = w_first | (r_eq & w_eq_max & w_eq_min);
    assign out_max    = r_out_max;
    assign out_min    = r_out_min;
    assign out_count  = r_out_cnt;
    assign out_all_eq = r_out_eq;

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == REPORT)
            w_state_nxt = out_ready ? IDLE : REPORT;
        else if (w_beat)
            w_state_nxt = in_last ? REPORT : ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_alive   <= 1'b0;
            r_max     <= '0;
            r_min     <= '0;
            r_cnt     <= '0;
            r_eq      <= 1'b0;
            r_out_max <= '0;
            r_out_min <= '0;
            r_out_cnt <= '0;
            r_out_eq  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            if (w_beat) begin
                r_max <= w_max_nxt;
                r_min <= w_min_nxt;
                r_cnt <= w_cnt_nxt;
                r_eq  <= w_eq_nxt;
            end
            if (w_beat && in_last) begin
                r_out_max <= w_max_nxt;
                r_out_min <= w_min_nxt;
                r_out_cnt <= w_cnt_nxt;
                r_out_eq  <= w_eq_nxt;
            end
        end
    end

`ifdef STREAM_MINMAX_INDEX_EN
    logic [CNT_W-1:0] r_max_idx;
    logic [CNT_W-1:0] r_min_idx;
    logic [CNT_W-1:0] r_out_max_idx;
    logic [CNT_W-1:0] r_out_min_idx;
    logic [CNT_W-1:0] w_max_idx_nxt;
    logic [CNT_W-1:0] w_min_idx_nxt;

    // r_cnt is the zero-based position of the current beat and already saturates
    assign w_max_idx_nxt = w_first ? '0 : (w_gt_max ? r_cnt : r_max_idx);
    assign w_min_idx_nxt = w_first ? '0 : (w_lt_min ? r_cnt : r_min_idx);
    assign out_max_idx   = r_out_max_idx;
    assign out_min_idx   = r_out_min_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_max_idx     <= '0;
            r_min_idx     <= '0;
            r_out_max_idx <= '0;
            r_out_min_idx <= '0;
        end else begin
            if (w_beat) begin
                r_max_idx <= w_max_idx_nxt;
                r_min_idx <= w_min_idx_nxt;
            end
            if (w_beat && in_last) begin
                r_out_max_idx <= w_max_idx_nxt;
                r_out_min_idx <= w_min_idx_nxt;
            end
        end
    end
`endif
endmodule

// File: tb/tb_stream_minmax.sv
// tb_stream_minmax: randomized self-checking bench for stream_minmax against a frame-level reference model.
module tb_stream_minmax;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, out_all_eq;
    logic [31:0] in_data, out_max, out_min;
    logic [15:0] out_count;
    logic        s_in_valid, s_in_ready, s_in_last, s_out_valid, s_out_ready, s_out_all_eq;
    logic [7:0]  s_in_data, s_out_max, s_out_min;
    logic [1:0]  s_out_count;
`ifdef STREAM_MINMAX_INDEX_EN
    logic [15:0] out_max_idx, out_min_idx;
    logic [1:0]  s_out_max_idx, s_out_min_idx;
`endif
    int          pass_cnt = 0;
    int          chk_cnt = 0;
    logic [31:0] q[$];
    logic [31:0] e_max, e_min;
    int          e_cnt, e_mxi, e_mni;
    logic        e_eq;

    always #5 clk = ~clk;

    stream_minmax dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_max    (out_max),
        .out_min    (out_min),
        .out_count  (out_count),
        .out_all_eq (out_all_eq)
`ifdef STREAM_MINMAX_INDEX_EN
        ,
        .out_max_idx(out_max_idx),
        .out_min_idx(out_min_idx)
`endif
    );

    stream_minmax #(.WIDTH(8), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_data    (s_in_data),
        .in_last    (s_in_last),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_max    (s_out_max),
        .out_min    (s_out_min),
        .out_count  (s_out_count),
        .out_all_eq (s_out_all_eq)
`ifdef STREAM_MINMAX_INDEX_EN
        ,
        .out_max_idx(s_out_max_idx),
        .out_min_idx(s_out_min_idx)
`endif
    );

    // Frame summary straight from the definitions: first occurrence wins, count and positions clip at cap.
    function automatic void model(input int cap);
        e_max = q[0];
        e_min = q[0];
        e_eq  = 1'b1;
        e_mxi = 0;
        e_mni = 0;
        foreach (q[i]) begin
            if (q[i] > e_max) begin
                e_max = q[i];
                e_mxi = (i < cap) ? i : cap;
            end
            if (q[i] < e_min) begin
                e_min = q[i];
                e_mni = (i < cap) ? i : cap;
            end
            if (q[i] != q[0]) e_eq = 1'b0;
        end
        e_cnt = (q.size() < cap) ? q.size() : cap;
    endfunction

    task automatic drive_frame(input bit sel);
        foreach (q[i]) begin
            in_valid = 1'b0;
            s_in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (sel) begin
                s_in_valid = 1'b1;
                s_in_data  = q[i][7:0];
                s_in_last  = (i == q.size() - 1);
            end else begin
                in_valid = 1'b1;
                in_data  = q[i];
                in_last  = (i == q.size() - 1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        s_in_valid = 1'b0;
        s_in_last = 1'b0;
    endtask

    task automatic release_out(input bit sel);
        if (sel) s_out_ready = 1'b1;
        else out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        s_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_ready, out_valid, out_max, out_min, out_count, out_all_eq} !== '0)
            $display("FAIL reset_state: got rdy=%b vld=%b max=%h min=%h cnt=%0d eq=%b want all 0",
                     in_ready, out_valid, out_max, out_min, out_count, out_all_eq);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_cnt++;
        if (in_ready !== 1'b0) $display("FAIL ready_before_edge: got %b want 0", in_ready);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_edge: got %b want 1", in_ready);
        else pass_cnt++;
    endtask

    task automatic test_equal_pair;
        q = '{32'd10, 32'd10};
        drive_frame(0);
        chk_cnt++;
        if ({out_valid, out_max, out_min, out_count, out_all_eq} !== {1'b1, 32'd10, 32'd10, 16'd2, 1'b1})
            $display("FAIL equal_pair: got vld=%b max=%0d min=%0d cnt=%0d eq=%b want 1 10 10 2 1",
                     out_valid, out_max, out_min, out_count, out_all_eq);
        else pass_cnt++;
`ifdef STREAM_MINMAX_INDEX_EN
        chk_cnt++;
        if ({out_max_idx, out_min_idx} !== {16'd0, 16'd0})
            $display("FAIL equal_pair_idx: got %0d %0d want 0 0", out_max_idx, out_min_idx);
        else pass_cnt++;
`endif
        release_out(0);
    endtask

    task automatic test_mixed_frame;
        q = '{32'd100, 32'd120, 32'd50, 32'd556, 32'd9807};
        drive_frame(0);
        chk_cnt++;
        if ({out_valid, out_max, out_min, out_count, out_all_eq} !== {1'b1, 32'd9807, 32'd50, 16'd5, 1'b0})
            $display("FAIL mixed_frame: got vld=%b max=%0d min=%0d cnt=%0d eq=%b want 1 9807 50 5 0",
                     out_valid, out_max, out_min, out_count, out_all_eq);
        else pass_cnt++;
`ifdef STREAM_MINMAX_INDEX_EN
        chk_cnt++;
        if ({out_max_idx, out_min_idx} !== {16'd4, 16'd2})
            $display("FAIL mixed_frame_idx: got %0d %0d want 4 2", out_max_idx, out_min_idx);
        else pass_cnt++;
`endif
        release_out(0);
    endtask

    task automatic test_single_max;
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        in_last  = 1'b1;
        #1;
        chk_cnt++;
        if (out_valid !== 1'b0) $display("FAIL single_valid_early: got %b want 0", out_valid);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_cnt++;
        if ({out_valid, out_max, out_min, out_count, out_all_eq} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd1, 1'b1})
            $display("FAIL single_max: got vld=%b max=%h min=%h cnt=%0d eq=%b want 1 ffffffff ffffffff 1 1",
                     out_valid, out_max, out_min, out_count, out_all_eq);
        else pass_cnt++;
        release_out(0);
    endtask

    task automatic test_backpressure;
        bit bad = 0;
        q = '{32'd3, 32'd9, 32'd1, 32'd9};
        model(65535);
        drive_frame(0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~i[0];
            in_data  = $urandom;
            in_last  = 1'b1;
            @(negedge clk);
            if ({out_valid, in_ready, out_max, out_min, out_count, out_all_eq} !==
                {1'b1, 1'b0, e_max, e_min, 16'(e_cnt), e_eq}) begin
                bad = 1;
                $display("FAIL hold_cycle%0d: got vld=%b rdy=%b max=%0d min=%0d cnt=%0d want 1 0 %0d %0d %0d",
                         i, out_valid, in_ready, out_max, out_min, out_count, e_max, e_min, e_cnt);
            end
        end
        chk_cnt++;
        if (!bad) pass_cnt++;
        in_valid = 1'b1;
        in_data  = 32'd999;
        in_last  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        out_ready = 1'b0;
        chk_cnt++;
        if ({out_valid, in_ready} !== 2'b01) $display("FAIL release_state: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        else pass_cnt++;
        @(negedge clk);
        chk_cnt++;
        if ({out_valid, out_max, out_min} !== {1'b0, e_max, e_min})
            $display("FAIL release_no_accept: got vld=%b max=%0d min=%0d want 0 %0d %0d", out_valid, out_max, out_min, e_max, e_min);
        else pass_cnt++;
    endtask

    task automatic test_saturate;
        q.delete();
        for (int i = 0; i < 6; i++) q.push_back(32'($urandom_range(0, 255)));
        model(3);
        drive_frame(1);
        chk_cnt++;
        if ({s_out_valid, s_out_max, s_out_min, s_out_count, s_out_all_eq} !== {1'b1, e_max[7:0], e_min[7:0], 2'(e_cnt), e_eq})
            $display("FAIL saturate: got vld=%b max=%0d min=%0d cnt=%0d eq=%b want 1 %0d %0d %0d %b",
                     s_out_valid, s_out_max, s_out_min, s_out_count, s_out_all_eq, e_max, e_min, e_cnt, e_eq);
        else pass_cnt++;
        chk_cnt++;
        if (s_out_count !== 2'd3) $display("FAIL saturate_count: got %0d want 3", s_out_count);
        else pass_cnt++;
`ifdef STREAM_MINMAX_INDEX_EN
        chk_cnt++;
        if ({s_out_max_idx, s_out_min_idx} !== {2'(e_mxi), 2'(e_mni)})
            $display("FAIL saturate_idx: got %0d %0d want %0d %0d", s_out_max_idx, s_out_min_idx, e_mxi, e_mni);
        else pass_cnt++;
`endif
        release_out(1);
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_data  = 32'd7;
        @(posedge clk);
        @(negedge clk);
        in_data = 32'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_cnt++;
        if ({in_ready, out_valid, out_max, out_min, out_count, out_all_eq} !== '0)
            $display("FAIL mid_reset_state: got rdy=%b vld=%b max=%0d min=%0d cnt=%0d want all 0",
                     in_ready, out_valid, out_max, out_min, out_count);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (out_valid) seen = 1;
        end
        chk_cnt++;
        if (seen) $display("FAIL mid_reset_no_valid: got out_valid=1 want 0");
        else pass_cnt++;
        q = '{32'd5};
        drive_frame(0);
        chk_cnt++;
        if ({out_valid, out_max, out_min, out_count, out_all_eq} !== {1'b1, 32'd5, 32'd5, 16'd1, 1'b1})
            $display("FAIL after_reset_frame: got vld=%b max=%0d min=%0d cnt=%0d eq=%b want 1 5 5 1 1",
                     out_valid, out_max, out_min, out_count, out_all_eq);
        else pass_cnt++;
        release_out(0);
    endtask

    task automatic test_random;
        for (int f = 0; f < 30; f++) begin
            q.delete();
            for (int i = 0; i < int'($urandom_range(1, 8)); i++)
                q.push_back(f[0] ? 32'($urandom_range(0, 3)) : 32'($urandom));
            model(65535);
            drive_frame(0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            chk_cnt++;
            if ({out_valid, out_max, out_min, out_count, out_all_eq} !== {1'b1, e_max, e_min, 16'(e_cnt), e_eq})
                $display("FAIL random%0d: got vld=%b max=%h min=%h cnt=%0d eq=%b want 1 %h %h %0d %b",
                         f, out_valid, out_max, out_min, out_count, out_all_eq, e_max, e_min, e_cnt, e_eq);
            else pass_cnt++;
`ifdef STREAM_MINMAX_INDEX_EN
            chk_cnt++;
            if ({out_max_idx, out_min_idx} !== {16'(e_mxi), 16'(e_mni)})
                $display("FAIL random%0d_idx: got %0d %0d want %0d %0d", f, out_max_idx, out_min_idx, e_mxi, e_mni);
            else pass_cnt++;
`endif
            release_out(0);
        end
    endtask

    initial begin
        {in_valid, in_last, out_ready, s_in_valid, s_in_last, s_out_ready} = '0;
        in_data = '0;
        s_in_data = '0;
        test_reset;
        test_equal_pair;
        test_mixed_frame;
        test_single_max;
        test_backpressure;
        test_saturate;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
